// File: rtl/gray_counter_pkg.sv
// Shared Gray-code helpers and types for the Gray counter and its decode stage.
// Functions operate on a fixed maximum width; callers zero-extend and truncate.
package gray_counter_pkg;

  localparam int GRAY_W_DEFAULT = 4;
  localparam int GRAY_W_MAX     = 32;

  typedef logic [GRAY_W_MAX-1:0] gray_word_t;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_LOAD,
    OP_UP,
    OP_DOWN
  } count_op_e;

  function automatic gray_word_t bin2gray(input gray_word_t b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; zero upper bits leave narrower widths exact.
  function automatic gray_word_t gray2bin(input gray_word_t g);
    gray_word_t b;
    b[GRAY_W_MAX-1] = g[GRAY_W_MAX-1];
    for (int i = GRAY_W_MAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic count_op_e decode_op(input logic load, input logic en,
                                          input logic up_dn);
    if (load)    return OP_LOAD;
    else if (en) return up_dn ? OP_UP : OP_DOWN;
    else         return OP_HOLD;
  endfunction

endpackage

// File: rtl/gray_counter_if.sv
// Control and status bundle between a controller and the Gray counter.
interface gray_counter_if #(
  parameter int W = gray_counter_pkg::GRAY_W_DEFAULT
);

  logic         en;
  logic         up_dn;
  logic         wrap_en;
  logic         load;
  logic [W-1:0] load_gray;
  logic [W-1:0] gray;
  logic         tc;
  logic         step;

  modport master (
    output en, up_dn, wrap_en, load, load_gray,
    input  gray, tc, step
  );

  modport slave (
    input  en, up_dn, wrap_en, load, load_gray,
    output gray, tc, step
  );

endinterface

// File: rtl/gray_counter.sv
// Up/down Gray counter with parallel Gray load, wrap/saturate ends, terminal
// count and a one-cycle step pulse; gray is registered alongside the binary count.
module gray_counter
  import gray_counter_pkg::*;
#(
  parameter int W = GRAY_W_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  gray_counter_if.slave bus
);

  localparam logic [W-1:0] BIN_MAX = '1;
  localparam logic [W-1:0] BIN_ONE = W'(1);

  count_op_e    op;
  logic [W-1:0] bin_q, bin_d;
  logic [W-1:0] gray_q, gray_d;
  logic         step_q, step_d;
  logic [W-1:0] bin_inc, bin_dec;

  assign op      = decode_op(bus.load, bus.en, bus.up_dn);
  assign bin_inc = bin_q + BIN_ONE;
  assign bin_dec = bin_q - BIN_ONE;

  always_comb begin
    // NOTE: every next-state signal gets a default first, so no path can leave one unassigned and infer a latch.
    bin_d  = bin_q;
    gray_d = gray_q;
    step_d = 1'b0;
    unique case (op)
      OP_LOAD: begin
        bin_d  = W'(gray2bin(GRAY_W_MAX'(bus.load_gray)));
        gray_d = bus.load_gray;
      end
      OP_UP: begin
        if (bin_q != BIN_MAX || bus.wrap_en) begin
          bin_d  = bin_inc;
          gray_d = W'(bin2gray(GRAY_W_MAX'(bin_inc)));
          step_d = 1'b1;
        end
      end
      OP_DOWN: begin
        if (bin_q != '0 || bus.wrap_en) begin
          bin_d  = bin_dec;
          gray_d = W'(bin2gray(GRAY_W_MAX'(bin_dec)));
          step_d = 1'b1;
        end
      end
      OP_HOLD: ;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q  <= '0;
      gray_q <= '0;
      step_q <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so bin, gray and step all move together on the same edge.
      bin_q  <= bin_d;
      gray_q <= gray_d;
      step_q <= step_d;
    end
  end

  assign bus.gray = gray_q;
  assign bus.step = step_q;
  assign bus.tc   = bus.up_dn ? (bin_q == BIN_MAX) : (bin_q == '0);

endmodule

// File: tb/tb_gray_counter.sv
// Directed and randomized check of gray_counter against an arithmetic count model.
module tb_gray_counter;
  import gray_counter_pkg::*;

  localparam int W    = GRAY_W_DEFAULT;
  localparam int MAXV = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  gray_counter_if #(.W(W)) bus ();

  gray_counter #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   vectors     = 0;
  int   miscompares = 0;
  int   m_bin;
  logic m_step;
  logic [3:0] seq [16];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour from the counting rules, using plain integer arithmetic.
  task automatic model_edge();
    int nxt;
    if (bus.load) begin
      m_bin  = int'(gray2bin(32'(bus.load_gray)));
      m_step = 1'b0;
    end else if (bus.en) begin
      nxt = bus.up_dn ? m_bin + 1 : m_bin - 1;
      if (nxt > MAXV || nxt < 0) nxt = bus.wrap_en ? (bus.up_dn ? 0 : MAXV) : m_bin;
      m_step = (nxt != m_bin);
      m_bin  = nxt;
    end else begin
      m_step = 1'b0;
    end
  endtask

  task automatic tick();
    logic [W-1:0] prev_gray;
    logic         was_load;
    logic         exp_tc;
    prev_gray = bus.gray;
    was_load  = bus.load;
    @(posedge clk);
    model_edge();
    #1;
    exp_tc = (bus.up_dn && m_bin == MAXV) || (!bus.up_dn && m_bin == 0);
    check("gray",   32'(bus.gray), bin2gray(32'(m_bin)));
    check("step",   32'(bus.step), 32'(m_step));
    check("tc",     32'(bus.tc),   32'(exp_tc));
    check("decode", gray2bin(32'(bus.gray)), 32'(m_bin));
    if (!was_load)
      check("hamming", 32'($countones(prev_gray ^ bus.gray) <= 1), 32'(1));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    m_bin  = 0;
    m_step = 1'b0;
    check("rst_gray", 32'(bus.gray), 32'(0));
    check("rst_step", 32'(bus.step), 32'(0));
    rst = 1'b0;
  endtask

  initial begin
    seq = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
            4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
    bus.en = 1'b0; bus.up_dn = 1'b1; bus.wrap_en = 1'b1;
    bus.load = 1'b0; bus.load_gray = '0;
    m_bin = 0; m_step = 1'b0;
    #1;

    // Reset and a full up cycle with wrap
    do_reset();
    bus.en = 1'b1; bus.up_dn = 1'b1; bus.wrap_en = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check("t1_seq", 32'(bus.gray), 32'(seq[k % 16]));
    end

    // Saturate at the top, then turn around
    for (int k = 0; k < 15; k++) tick();
    check("t2_top", 32'(bus.gray), 32'(4'b1000));
    bus.wrap_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t2_sat", 32'(bus.gray), 32'(4'b1000));
    end
    bus.up_dn = 1'b0;
    #1;
    check("t2_tc_dir", 32'(bus.tc), 32'(0));
    tick();
    check("t2_down", 32'(bus.gray), 32'(4'b1001));

    // Load wins over en, then count down
    bus.load = 1'b1; bus.load_gray = 4'b1011; bus.en = 1'b1; bus.up_dn = 1'b1;
    tick();
    check("t3_load", 32'(bus.gray), 32'(4'b1011));
    check("t3_step", 32'(bus.step), 32'(0));
    bus.load = 1'b0; bus.up_dn = 1'b0;
    tick();
    check("t3_dn1", 32'(bus.gray), 32'(4'b1010));
    tick();
    check("t3_dn2", 32'(bus.gray), 32'(4'b1110));

    // Idle: changing direction, wrap and load value does nothing
    bus.en = 1'b0;
    bus.up_dn = 1'b1; bus.wrap_en = 1'b1; bus.load_gray = 4'b0101;
    tick();
    check("idle", 32'(bus.gray), 32'(4'b1110));

    // Down-wrap at zero, and down-saturate at zero
    do_reset();
    bus.en = 1'b1; bus.up_dn = 1'b0; bus.wrap_en = 1'b1;
    tick();
    check("t4_wrap", 32'(bus.gray), 32'(4'b1000));
    check("t4_wstep", 32'(bus.step), 32'(1));
    bus.en = 1'b0;
    #1;
    do_reset();
    bus.en = 1'b1; bus.wrap_en = 1'b0;
    tick();
    check("t4_sat", 32'(bus.gray), 32'(4'b0000));
    check("t4_tc", 32'(bus.tc), 32'(1));

    // Asynchronous reset between edges while counting
    bus.en = 1'b0;
    #1;
    do_reset();
    bus.en = 1'b1; bus.up_dn = 1'b1; bus.wrap_en = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    check("t5_pre", 32'(bus.gray), 32'(4'b0110));
    #2;
    do_reset();
    tick();
    check("t5_resume", 32'(bus.gray), 32'(4'b0001));

    // Randomized scoreboard
    for (int k = 0; k < 2000; k++) begin
      bus.en        = ($urandom_range(0, 3) != 0);
      bus.up_dn     = 1'($urandom_range(0, 1));
      bus.wrap_en   = 1'($urandom_range(0, 1));
      bus.load      = ($urandom_range(0, 15) == 0);
      bus.load_gray = W'($urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gray_counter.md
Name: gray_counter

Overview:
Synchronous up/down Gray-code counter that sits directly upstream of the Gray-to-binary decode stage and drives its g-inputs. It keeps an internal binary count and presents a registered Gray output that changes by exactly one bit per step. It supports parallel load of a Gray value, wrap or saturate at the ends, a terminal-count flag, and a one-cycle step pulse.

Parameters:
W, 4, counter width in bits (W >= 2); MSB maps to g3 and LSB to g0 for the 4-bit decode stage.

Ports:
clk  in  1  rising-edge clock.
rst  in  1  asynchronous, active-high reset.
en  in  1  count enable; one step per cycle while high.
up_dn  in  1  direction: 1 = up, 0 = down.
wrap_en  in  1  1 = wrap at the ends; 0 = saturate at the ends.
load  in  1  synchronous parallel load; takes priority over en.
load_gray  in  W  Gray value to load.
gray  out  W  registered Gray count; feeds the decode stage.
tc  out  1  terminal count for the current direction (combinational).
step  out  1  registered; high for one cycle after gray changed due to counting.

Behaviour:
- Reset: rst high asynchronously forces bin = 0, gray = 0 and step = 0. Release is synchronous-safe; the first count happens on the first rising edge after rst falls with en = 1. Reset mid-count abandons the step.
- State: internal bin[W-1:0]. The gray register always equals bin ^ (bin >> 1) of the same cycle; both registers update on the same edge. There is no combinational path from inputs to gray.
- Priority per edge: rst > load > en > hold.
- load = 1:
  - bin <= gray2bin(load_gray); gray <= load_gray.
  - step <= 0.
  - en and up_dn are ignored that cycle.
  - Loading any W-bit value is legal.
- en = 1, load = 0:
  - up_dn = 1: bin <= bin + 1 (mod 2^W).
  - up_dn = 0: bin <= bin - 1 (mod 2^W).
  - step <= 1 if the count changed, else 0.
- Boundaries:
  - Up at bin = 2^W-1 (gray = 10..0): wrap_en = 1 gives bin 0 (gray 0..0), step = 1; wrap_en = 0 holds the value, step = 0.
  - Down at bin = 0: wrap_en = 1 gives bin 2^W-1 (gray 10..0), step = 1; wrap_en = 0 holds the value, step = 0.
- Hold (en = 0, load = 0): bin and gray unchanged; step <= 0.
- tc = (up_dn & bin == 2^W-1) | (~up_dn & bin == 0). It follows up_dn combinationally and is independent of en and wrap_en.
- Invariant: between any two consecutive clock edges without load, gray differs in at most one bit, including across the wrap.
- Latency: gray reflects a load or step one clock after the sampling edge. step is aligned with the new gray value.
- Changing up_dn, wrap_en or load_gray while idle has no effect on gray.

Decomposition:
- Shared package holds:
  - constant GRAY_W_DEFAULT = 4.
  - function bin2gray(b) = b ^ (b >> 1).
  - function gray2bin(g): prefix XOR from the MSB down, b[i] = ^g[W-1:i].
  - The decode stage and the bench reuse these functions as the reference model.
- No sub-module: a single always block for bin/gray/step plus a continuous assign for tc. The load-path decode is the package function, not an instance of the decode stage, to keep this block self-contained.

Test Plan:
1. Reset and count up: rst pulse, then en = 1, up_dn = 1, wrap_en = 1 for 16 cycles -> gray sequence 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, then back to 0000. step = 1 every cycle; tc = 1 only while gray = 1000.
2. Saturate: count to gray 1000, set wrap_en = 0 with en held high for 3 cycles -> gray stays 1000, step = 0, tc = 1. Then up_dn = 0 -> next gray 1001 (bin 14).
3. Load then count down: load = 1, load_gray = 1011 (bin 13), en = 1 the same cycle -> gray = 1011 and step = 0 next cycle. Then down for 2 cycles -> 1010, then 1110.
4. Down-wrap at zero: from reset, up_dn = 0, wrap_en = 1, en = 1 -> gray 1000 (bin 15), step = 1. The same from reset with wrap_en = 0 -> gray stays 0000, tc = 1.
5. Async reset mid-operation: assert rst between edges while counting at gray 0110 -> gray = 0000 and step = 0 immediately, without waiting for a clock edge. Count resumes from 0001 after release.
6. Scoreboard with random en/up_dn/wrap_en/load for 2000 cycles -> gray2bin(gray) matches the model every cycle. Hamming distance between consecutive gray values is <= 1 on non-load cycles. Chaining the output into the decode stage yields dcba = model binary.
